i2c_slave_mem: RTL
==================

# i2c_slave_mem

Synthesizable single-address I2C slave with a small byte-addressed register memory, sitting on the bus side of the i2cmb master, one instance per I2C bus. Consumes the SCL/SDA traffic the master generates: acknowledges its address, accepts pointer and data writes, and returns memory bytes on reads. Write strobes are exported for the environment's scoreboard. Oversamples the bus with the system clock, so SCL is never used as a clock.

## Interface

- SLAVE_ADDR, 7'h22, 7-bit I2C address this slave answers to
- PTR_W, 4, pointer width; memory depth is 2**PTR_W bytes
- clk_i  in  1  system clock; must be at least 16× the SCL frequency
- rst_i  in  1  reset; one clock; reset is synchronous and active-high
- scl_i  in  1  SCL pin level (asynchronous)
- sda_i  in  1  SDA pin level (asynchronous)
- sda_drive_o  out  1  1 = pull SDA low (open drain); 0 = release
- busy_o  out  1  high from the addressed START until STOP or NACK/mismatch release
- start_det_o  out  1  one-cycle pulse per START or repeated START
- stop_det_o  out  1  one-cycle pulse per STOP
- wr_strobe_o  out  1  one-cycle pulse per memory data byte written
- wr_addr_o  out  PTR_W  memory address of the write; valid with wr_strobe_o
- wr_data_o  out  8  byte written; valid with wr_strobe_o

## Operation

- Input path: scl_i and sda_i each pass through a 2-flop synchronizer, then a third flop for edge detection. All decisions use the synchronized values.
- START: SDA falls while SCL is high. STOP: SDA rises while SCL is high. Both are recognized in any state.
- START enters ADDR and clears the bit counter. STOP enters IDLE, releases SDA, and clears busy_o.
- Data is sampled on each SCL rising edge. sda_drive_o changes only on the cycle after an SCL falling edge is detected.
- FSM states: IDLE, ADDR, ADDR_ACK, PTR, WR_BYTE, WR_ACK, RD_BYTE, RD_ACK, IGNORE.
- ADDR: shifts in 8 bits, MSB first.
  - Bits[7:1] == SLAVE_ADDR: go to ADDR_ACK and set busy_o.
  - Otherwise: go to IGNORE, never drive, and stay there until START or STOP.
- ADDR_ACK: drive low from the 8th falling edge to the 9th falling edge.
  - R/W=0: go to PTR.
  - R/W=1: go to RD_BYTE and drive bit 7 of mem[ptr] from the 9th falling edge.
- PTR: the first written byte loads ptr with its low PTR_W bits, is acknowledged, then the FSM goes to WR_BYTE. No wr_strobe_o is issued for this byte.
- WR_BYTE: after 8 bits, write mem[ptr], pulse wr_strobe_o with the pre-increment ptr, go to WR_ACK (drive ACK), then ptr increments.
- RD_BYTE: drive the 8 bits of mem[ptr], MSB first. A 0 bit drives low; a 1 bit releases. After 8 bits, release and go to RD_ACK.
- RD_ACK: sample SDA on the rising edge.
  - 0 (ACK): ptr increments; go to RD_BYTE and drive the next byte.
  - 1 (NACK): go to IGNORE and clear busy_o.
- Pointer wrap: ptr increments modulo 2**PTR_W (0xF → 0x0 at default).
- Repeated START mid-transfer: abandon the current byte with no write, release SDA, keep ptr, and enter ADDR.

## Timing

- Reset values: sda_drive_o=0, busy_o=0, all pulses 0, wr_addr_o=0, wr_data_o=0, ptr=0, all memory bytes 8'h00, state IDLE.
- Reset mid-operation, including while driving SDA low: outputs and state reach reset values on the first clk_i edge with rst_i high.
- Pin edge to detection: 3 clk_i cycles.
- START/STOP pulse: asserted the cycle after detection.
- wr_strobe_o: asserted on the cycle after the 8th data bit's rising edge is detected.
- sda_drive_o: updates on the cycle after a falling edge is detected, i.e. 4 clk_i cycles after the SCL pin falls.
- START and STOP cannot coincide. An SDA edge while SCL is high always takes START/STOP priority over bit sampling.

## Test plan

- Reset: hold rst_i 2 cycles mid-bus-idle → all outputs 0; a read of mem[0] returns 0x00.
- Write: START, 0x44, 0x03, 0xA5, 0x5A, STOP → four ACKs; wr_strobe_o pulses twice with (3, A5) then (4, 5A); stop_det_o pulses; busy_o returns to 0.
- Read: START 0x44 0x03, repeated START, 0x45; master ACKs byte 1 and NACKs byte 2 → returns A5, 5A; two start_det_o pulses; SDA released after NACK.
- Mismatch: START 0x46, 0x11 → sda_drive_o stays 0 throughout; busy_o stays 0; no strobes.
- Wrap: pointer 0x0F, write 0x01, 0x02, 0x03 → strobes at addresses F, 0, 1.
- Reset while driving: assert rst_i during the ADDR ACK low phase → sda_drive_o=0 after one clk_i edge; the next START 0x44 is acknowledged normally.

Source files
------------

// File: rtl/i2c_slave_mem_if.sv
// rtl/i2c_slave_mem_if.sv - I2C pin and write-strobe bundle for i2c_slave_mem
interface i2c_slave_mem_if #(
  parameter int PTR_W = 4
);
  logic             scl_i;
  logic             sda_i;
  logic             sda_drive_o;
  logic             busy_o;
  logic             start_det_o;
  logic             stop_det_o;
  logic             wr_strobe_o;
  logic [PTR_W-1:0] wr_addr_o;
  logic [7:0]       wr_data_o;

  modport master (
    output scl_i, sda_i,
    input  sda_drive_o, busy_o, start_det_o, stop_det_o, wr_strobe_o, wr_addr_o, wr_data_o
  );

  modport slave (
    input  scl_i, sda_i,
    output sda_drive_o, busy_o, start_det_o, stop_det_o, wr_strobe_o, wr_addr_o, wr_data_o
  );
endinterface

// File: rtl/i2c_slave_mem.sv
// rtl/i2c_slave_mem.sv - oversampled single-address I2C slave with byte register memory
module i2c_slave_mem #(
  parameter logic [6:0] SLAVE_ADDR = 7'h22,
  parameter int         PTR_W      = 4
) (
  input logic            clk_i,
  input logic            rst_i,
  i2c_slave_mem_if.slave bus
);
  localparam int DEPTH = 2 ** PTR_W;

  typedef enum logic [3:0] {
    IDLE, ADDR, ADDR_ACK, PTR, WR_BYTE, WR_ACK, RD_BYTE, RD_ACK, IGNORE
  } state_t;

  state_t           state;
  logic [2:0]       scl_sync;
  logic [2:0]       sda_sync;
  logic [3:0]       bit_cnt;
  logic [6:0]       shreg;
  logic             rw;
  logic [PTR_W-1:0] ptr;
  logic [7:0]       mem [DEPTH];

  logic       scl_rise, scl_fall, start_cond, stop_cond;
  logic [7:0] byte_in;
  logic [7:0] rd_byte;

  // Index [1] is the synchronized level, [2] its previous value.
  assign scl_rise   = scl_sync[1] & ~scl_sync[2];
  assign scl_fall   = ~scl_sync[1] & scl_sync[2];
  assign start_cond = scl_sync[1] & scl_sync[2] & sda_sync[2] & ~sda_sync[1];
  assign stop_cond  = scl_sync[1] & scl_sync[2] & ~sda_sync[2] & sda_sync[1];
  assign byte_in    = {shreg, sda_sync[1]};
  assign rd_byte    = mem[ptr];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state           <= IDLE;
      scl_sync        <= 3'b111;
      sda_sync        <= 3'b111;
      bit_cnt         <= '0;
      shreg           <= '0;
      rw              <= 1'b0;
      ptr             <= '0;
      bus.sda_drive_o <= 1'b0;
      bus.busy_o      <= 1'b0;
      bus.start_det_o <= 1'b0;
      bus.stop_det_o  <= 1'b0;
      bus.wr_strobe_o <= 1'b0;
      bus.wr_addr_o   <= '0;
      bus.wr_data_o   <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      scl_sync        <= {scl_sync[1:0], bus.scl_i};
      sda_sync        <= {sda_sync[1:0], bus.sda_i};
      bus.start_det_o <= 1'b0;
      bus.stop_det_o  <= 1'b0;
      bus.wr_strobe_o <= 1'b0;
      if (start_cond) begin
        // Also covers repeated START: a partial byte is simply dropped.
        state           <= ADDR;
        bit_cnt         <= '0;
        bus.sda_drive_o <= 1'b0;
        bus.start_det_o <= 1'b1;
      end else if (stop_cond) begin
        state           <= IDLE;
        bit_cnt         <= '0;
        bus.sda_drive_o <= 1'b0;
        bus.busy_o      <= 1'b0;
        bus.stop_det_o  <= 1'b1;
      end else begin
        case (state)
          ADDR, PTR, WR_BYTE: begin
            if (scl_rise) begin
              shreg   <= byte_in[6:0];
              bit_cnt <= bit_cnt + 4'd1;
              if (bit_cnt == 4'd7) begin
                bit_cnt <= '0;
                if (state == ADDR) begin
                  if (byte_in[7:1] == SLAVE_ADDR) begin
                    state      <= ADDR_ACK;
                    bus.busy_o <= 1'b1;
                    rw         <= byte_in[0];
                  end else begin
                    state      <= IGNORE;
                    bus.busy_o <= 1'b0;
                  end
                end else if (state == PTR) begin
                  ptr   <= byte_in[PTR_W-1:0];
                  state <= WR_ACK;
                end else begin
                  mem[ptr]        <= byte_in;
                  bus.wr_strobe_o <= 1'b1;
                  bus.wr_addr_o   <= ptr;
                  bus.wr_data_o   <= byte_in;
                  ptr             <= ptr + PTR_W'(1);
                  state           <= WR_ACK;
                end
              end
            end
          end
          // ACK is held from the 8th falling edge to the 9th.
          ADDR_ACK: begin
            if (scl_fall) begin
              if (!bus.sda_drive_o) begin
                bus.sda_drive_o <= 1'b1;
              end else if (rw) begin
                state           <= RD_BYTE;
                bus.sda_drive_o <= ~rd_byte[7];
                bit_cnt         <= 4'd1;
              end else begin
                state           <= PTR;
                bus.sda_drive_o <= 1'b0;
              end
            end
          end
          WR_ACK: begin
            if (scl_fall) begin
              if (!bus.sda_drive_o) begin
                bus.sda_drive_o <= 1'b1;
              end else begin
                state           <= WR_BYTE;
                bus.sda_drive_o <= 1'b0;
              end
            end
          end
          RD_BYTE: begin
            if (scl_fall) begin
              if (bit_cnt == 4'd8) begin
                bus.sda_drive_o <= 1'b0;
                state           <= RD_ACK;
              end else begin
                bus.sda_drive_o <= ~rd_byte[3'd7 - bit_cnt[2:0]];
                bit_cnt         <= bit_cnt + 4'd1;
              end
            end
          end
          RD_ACK: begin
            if (scl_rise) begin
              if (!sda_sync[1]) begin
                ptr     <= ptr + PTR_W'(1);
                bit_cnt <= '0;
                state   <= RD_BYTE;
              end else begin
                state      <= IGNORE;
                bus.busy_o <= 1'b0;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end
endmodule
